multiplier_controller: RTL and testbench

- Control FSM for the shift-add multiplier datapath; sits directly upstream of the iteration counter.
- Drives the counter's RESET and DECREMENT inputs and consumes its 3-bit count.
- Issues load/add/shift strobes to the operand and product registers.
- Exposes a start/ready/done handshake to the surrounding system.

---
 rtl/multiplier_controller_pkg.sv | 16 +
 rtl/multiplier_controller_if.sv | 27 ++
 rtl/multiplier_controller.sv | 87 ++++++++
 tb/tb_multiplier_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/multiplier_controller_pkg.sv
// Shared constants and state type for the shift-add multiplier controller.
package mult_pkg;

    localparam int MULT_WIDTH = 4;
    localparam int COUNT_W    = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/multiplier_controller_if.sv
// Handshake, counter and datapath strobe bundle between the controller and its neighbours.
interface multiplier_controller_if
    import mult_pkg::*;
    ();

    logic               start;
    logic [COUNT_W-1:0] count;
    logic               q0;
    logic               ctr_reset;
    logic               ctr_decrement;
    logic               load;
    logic               add;
    logic               shift;
    logic               ready;
    logic               done;

    modport master (
        input  start, count, q0,
        output ctr_reset, ctr_decrement, load, add, shift, ready, done
    );

    modport slave (
        output start, count, q0,
        input  ctr_reset, ctr_decrement, load, add, shift, ready, done
    );

endinterface

// File: rtl/multiplier_controller.sv
// Moore control FSM for the shift-add multiplier: sequences load, add/shift
// iterations against the external iteration counter and signals completion.
module multiplier_controller
    import mult_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_reset,
    multiplier_controller_if.master bus
);

    ctrl_state_t state;
    ctrl_state_t state_next;

    logic ctr_reset_q;
    logic ctr_decrement_q;
    logic load_q;
    logic add_q;
    logic shift_q;
    logic ready_q;
    logic done_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode from state only; count and q0 steer just the TEST exit.
    // Any count other than zero (even beyond MULT_WIDTH) keeps the loop going.
    always_comb begin
        state_next      = IDLE;
        ctr_reset_q     = 1'b0;
        ctr_decrement_q = 1'b0;
        load_q          = 1'b0;
        add_q           = 1'b0;
        shift_q         = 1'b0;
        ready_q         = 1'b0;
        done_q          = 1'b0;
        case (state)
            IDLE: begin
                ready_q    = 1'b1;
                state_next = bus.start ? INIT : IDLE;
            end
            INIT: begin
                load_q      = 1'b1;
                ctr_reset_q = 1'b1;
                state_next  = TEST;
            end
            TEST: begin
                if (bus.count == '0) begin
                    state_next = DONE;
                end else if (bus.q0) begin
                    state_next = ADD;
                end else begin
                    state_next = SHIFT;
                end
            end
            ADD: begin
                add_q      = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                shift_q         = 1'b1;
                ctr_decrement_q = 1'b1;
                state_next      = TEST;
            end
            DONE: begin
                done_q     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ctr_reset     = ctr_reset_q;
    assign bus.ctr_decrement = ctr_decrement_q;
    assign bus.load          = load_q;
    assign bus.add           = add_q;
    assign bus.shift         = shift_q;
    assign bus.ready         = ready_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_multiplier_controller.sv
// Self-checking bench: controller driven by a behavioural counter and shift-add datapath.
module tb_multiplier_controller;
    import mult_pkg::*;

    logic clk;
    logic n_reset;
    logic [3:0] op_a;
    logic [3:0] op_b;
    int checks;
    int errors;
    bit monitor_on;

    logic [COUNT_W-1:0] cnt;
    logic [8:0]         prod_reg;
    logic [3:0]         mcand;

    multiplier_controller_if bus ();

    multiplier_controller dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sibling counter and operand/product registers, sharing n_reset with the controller.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt      <= '0;
            prod_reg <= '0;
            mcand    <= '0;
        end else begin
            if (bus.ctr_reset) begin
                cnt <= COUNT_W'(MULT_WIDTH);
            end else if (bus.ctr_decrement) begin
                cnt <= cnt - 1'b1;
            end
            if (bus.load) begin
                mcand    <= op_a;
                prod_reg <= {5'b0, op_b};
            end else if (bus.add) begin
                prod_reg[8:4] <= {1'b0, prod_reg[7:4]} + {1'b0, mcand};
            end else if (bus.shift) begin
                prod_reg <= prod_reg >> 1;
            end
        end
    end

    assign bus.count = cnt;
    assign bus.q0    = prod_reg[0];

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int popcount(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n;
    endfunction

    always @(negedge clk) begin
        if (monitor_on && n_reset === 1'b1) begin
            check_output("no_reset_and_decrement", 32'(bus.ctr_reset && bus.ctr_decrement), 32'd0);
            check_output("no_add_and_shift", 32'(bus.add && bus.shift), 32'd0);
        end
    end

    // Called at the negedge of cycle 1 (INIT); follows the run to done and scores it.
    task automatic observe_run(input logic [3:0] a, input logic [3:0] b);
        int cyc = 1;
        int done_cyc = 0;
        int shifts = 0;
        logic [3:0] add_mask = '0;
        check_output("init_load", 32'(bus.load), 32'd1);
        check_output("init_ctr_reset", 32'(bus.ctr_reset), 32'd1);
        check_output("init_not_ready", 32'(bus.ready), 32'd0);
        while (done_cyc == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.add && shifts < 4) add_mask[shifts] = 1'b1;
            if (bus.shift) shifts++;
            if (bus.done) done_cyc = cyc;
        end
        check_output("done_cycle", 32'(done_cyc), 32'(3 + 2 * MULT_WIDTH + popcount(b)));
        check_output("add_iterations", 32'(add_mask), 32'(b));
        check_output("shift_count", 32'(shifts), 32'(MULT_WIDTH));
        check_output("product", 32'(prod_reg[7:0]), 32'(a) * 32'(b));
    endtask

    task automatic apply_start(input logic [3:0] a, input logic [3:0] b, input bit hold);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start_level(1'b1);
        @(negedge clk);
        if (!hold) start_level(1'b0);
        observe_run(a, b);
    endtask

    task automatic start_level(input logic v);
        bus.start = v;
    endtask

    initial begin
        int adds;
        int guard;
        logic [3:0] ra;
        logic [3:0] rb;
        checks     = 0;
        errors     = 0;
        monitor_on = 1'b0;
        bus.start  = 1'b0;
        op_a       = '0;
        op_b       = '0;

        n_reset = 1'b0;
        #12;
        check_output("reset_ready", 32'(bus.ready), 32'd1);
        check_output("reset_strobes", 32'({bus.load, bus.add, bus.shift, bus.done, bus.ctr_reset, bus.ctr_decrement}), 32'd0);
        @(negedge clk);
        n_reset    = 1'b1;
        monitor_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("idle_ready", 32'(bus.ready), 32'd1);
            check_output("idle_strobes", 32'({bus.load, bus.add, bus.shift, bus.done}), 32'd0);
        end

        apply_start(4'h5, 4'h0, 1'b0);
        @(negedge clk);
        check_output("ready_after_done", 32'(bus.ready), 32'd1);
        apply_start(4'hF, 4'hF, 1'b0);
        apply_start(4'h3, 4'hA, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            apply_start(ra, rb, 1'b0);
        end

        // Abort during the second ADD of a full-ones run.
        @(negedge clk);
        op_a = 4'h7;
        op_b = 4'hF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        adds  = 0;
        guard = 0;
        while (adds < 2 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus.add) adds++;
        end
        check_output("abort_reached_second_add", 32'(adds), 32'd2);
        #1;
        n_reset = 1'b0;
        #1;
        check_output("abort_ready", 32'(bus.ready), 32'd1);
        check_output("abort_strobes", 32'({bus.load, bus.add, bus.shift, bus.done, bus.ctr_reset, bus.ctr_decrement}), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        apply_start(4'h9, 4'hB, 1'b0);

        // Start held high: one ready cycle between runs, then straight back to INIT.
        apply_start(4'h2, 4'h6, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("b2b_ready", 32'(bus.ready), 32'd1);
            ra   = 4'($urandom);
            rb   = 4'($urandom);
            op_a = ra;
            op_b = rb;
            @(negedge clk);
            observe_run(ra, rb);
        end
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("final_idle", 32'(bus.ready), 32'd1);

        monitor_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
